player_controller: RTL and testbench

- Per-frame motion and shot sequencer for the player sprite and its single missile.
- Samples the keyboard keycode once per video frame and updates the player position, with clamping at the playfield edges.
- Launches, advances and retires one shot.
- Outputs (PlayerX/PlayerY, ShotX/ShotY, shot_active) feed the color mapper and hit logic directly.

---
 rtl/player_controller.sv | 144 ++++++++++++++
 tb/tb_player_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/player_controller.sv
// Per-frame player motion and single-shot sequencer: frame_clk is synchronised, then one IDLE->MOVE->SHOT->DONE pass runs per frame.
// Optional build macro PLAYER_AUTOFIRE_EN: holding space relaunches without requiring a key release between shots.
module player_controller #(
    parameter logic [9:0] X_START   = 10'd320,
    parameter logic [9:0] Y_POS     = 10'd440,
    parameter logic [9:0] X_MIN     = 10'd16,
    parameter logic [9:0] X_MAX     = 10'd623,
    parameter logic [9:0] STEP      = 10'd2,
    parameter logic [9:0] SHOT_STEP = 10'd4,
    parameter logic [9:0] SIZE      = 10'd8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       shot_hit,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [9:0] Player_size,
    output logic [9:0] ShotX,
    output logic [9:0] ShotY,
    output logic       shot_active,
    output logic       frame_done
);

    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic [1:0] {IDLE, MOVE, SHOT, DONE} state_t;

    state_t     state, state_next;
    logic [2:0] fsync;
    logic       frame_tick;
    logic       can_fire;
    logic       launch;

    // Edge limits are tested before stepping so the 10-bit position never wraps.
    function automatic logic [9:0] step_left(input logic [9:0] x);
        return (x < X_MIN + STEP) ? X_MIN : x - STEP;
    endfunction

    function automatic logic [9:0] step_right(input logic [9:0] x);
        return (x > X_MAX - STEP) ? X_MAX : x + STEP;
    endfunction

    assign PlayerY     = Y_POS;
    assign Player_size = SIZE;

    // fsync[1:0] is the two-flop synchroniser, fsync[2] the edge-detect history.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fsync <= 3'b000;
        end else begin
            fsync <= {fsync[1:0], frame_clk};
        end
    end

    assign frame_tick = fsync[1] & ~fsync[2];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = MOVE;
            MOVE:    state_next = SHOT;
            SHOT:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef PLAYER_AUTOFIRE_EN
    assign can_fire = 1'b1;
`else
    logic fire_armed;

    // Re-arms only on a SHOT pass that sees space released.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fire_armed <= 1'b1;
        end else if (launch) begin
            fire_armed <= 1'b0;
        end else if (state == SHOT && keycode != KEY_SPACE) begin
            fire_armed <= 1'b1;
        end
    end

    assign can_fire = fire_armed;
`endif

    assign launch = (state == SHOT) && !shot_active && (keycode == KEY_SPACE) && can_fire;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PlayerX <= X_START;
        end else if (state == MOVE) begin
            if (keycode == KEY_A) begin
                PlayerX <= step_left(PlayerX);
            end else if (keycode == KEY_D) begin
                PlayerX <= step_right(PlayerX);
            end
        end
    end

    // A hit outranks the SHOT update, so a cleared shot cannot relaunch in that same cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ShotX       <= 10'd0;
            ShotY       <= 10'd0;
            shot_active <= 1'b0;
        end else if (shot_hit && shot_active) begin
            shot_active <= 1'b0;
        end else if (state == SHOT) begin
            if (shot_active) begin
                if (ShotY <= SHOT_STEP) begin
                    shot_active <= 1'b0;
                end else begin
                    ShotY <= ShotY - SHOT_STEP;
                end
            end else if (launch) begin
                ShotX       <= PlayerX;
                ShotY       <= Y_POS - SIZE;
                shot_active <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == SHOT);
        end
    end

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench for player_controller: stimulus queues hand-computed per-frame results, a monitor checks them on frame_done.
module tb_player_controller;

    typedef struct {
        logic [9:0] px;
        logic       sa;
        logic [9:0] sx;
        logic [9:0] sy;
        logic [9:0] pxl;
        logic [9:0] pxz;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [7:0] key_l = 8'h00;
    logic [7:0] key_z = 8'h00;
    logic       shot_hit = 1'b0;
    logic       no_hit = 1'b0;

    logic [9:0] PlayerX, PlayerY, Player_size, ShotX, ShotY;
    logic       shot_active, frame_done;
    logic [9:0] l_px, l_py, l_size, l_sx, l_sy;
    logic       l_sa, l_fd;
    logic [9:0] z_px, z_py, z_size, z_sx, z_sy;
    logic       z_sa, z_fd;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #10 Clk = ~Clk;

    player_controller dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode), .shot_hit(shot_hit),
        .PlayerX(PlayerX), .PlayerY(PlayerY), .Player_size(Player_size), .ShotX(ShotX), .ShotY(ShotY),
        .shot_active(shot_active), .frame_done(frame_done)
    );

    // Starts one pixel right of the left limit.
    player_controller #(.X_START(10'd17)) dut_l (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(key_l), .shot_hit(no_hit),
        .PlayerX(l_px), .PlayerY(l_py), .Player_size(l_size), .ShotX(l_sx), .ShotY(l_sy),
        .shot_active(l_sa), .frame_done(l_fd)
    );

    // Left limit at zero: a naive subtract would wrap to 1023.
    player_controller #(.X_MIN(10'd0), .X_START(10'd1)) dut_z (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(key_z), .shot_hit(no_hit),
        .PlayerX(z_px), .PlayerY(z_py), .Player_size(z_size), .ShotX(z_sx), .ShotY(z_sy),
        .shot_active(z_sa), .frame_done(z_fd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n && frame_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_done actual=1 required=0 at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("PlayerX", PlayerX, mon_e.px);
                check("PlayerY", PlayerY, 440);
                check("shot_active", shot_active, mon_e.sa);
                if (mon_e.sa) begin
                    check("ShotX", ShotX, mon_e.sx);
                    check("ShotY", ShotY, mon_e.sy);
                end
                check("PlayerX_left_clamp", l_px, mon_e.pxl);
                check("PlayerX_zero_clamp", z_px, mon_e.pxz);
            end
        end
    end

    task automatic frame(input logic [7:0] k, input logic [7:0] kl, input logic [7:0] kz, input logic hit,
                         input logic [9:0] px, input logic sa, input logic [9:0] sx, input logic [9:0] sy,
                         input logic [9:0] pxl, input logic [9:0] pxz);
        int   cyc;
        exp_t e;
        keycode = k;
        key_l = kl;
        key_z = kz;
        e.px = px; e.sa = sa; e.sx = sx; e.sy = sy; e.pxl = pxl; e.pxz = pxz;
        sb.push_back(e);
        @(negedge Clk);
        frame_clk = 1'b1;
        cyc = 0;
        // The SHOT cycle sits between the 4th and 5th rising edge after frame_clk rises.
        do begin
            @(posedge Clk);
            cyc++;
            #1;
            shot_hit = hit && (cyc == 4);
        end while (!frame_done && cyc < 20);
        shot_hit = 1'b0;
        checks++;
        if (!frame_done || cyc < 3 || cyc > 5) begin
            errors++;
            $display("FAIL frame_latency actual=%0d required=3..5 cycles at %0t", cyc, $time);
        end
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        frame_clk = 1'b0;
        keycode = 8'h00;
        key_l = 8'h00;
        key_z = 8'h00;
        shot_hit = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_PlayerX", PlayerX, 320);
        check("rst_PlayerY", PlayerY, 440);
        check("rst_Player_size", Player_size, 8);
        check("rst_ShotX", ShotX, 0);
        check("rst_ShotY", ShotY, 0);
        check("rst_shot_active", shot_active, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_PlayerX_left", l_px, 17);
        check("rst_PlayerX_zero", z_px, 1);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        do_reset();

        // Idle frames: nothing moves.
        for (int i = 0; i < 10; i++) frame(8'h00, 8'h00, 8'h00, 1'b0, 320, 1'b0, 0, 0, 17, 1);

        // Left clamps on the secondary instances.
        for (int i = 0; i < 3; i++) frame(8'h00, 8'h04, 8'h04, 1'b0, 320, 1'b0, 0, 0, 16, 0);

        // Single tap of space, then flight to the top edge.
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 432, 16, 0);
        for (int j = 1; j <= 107; j++) frame(8'h00, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 10'(432 - 4 * j), 16, 0);
        frame(8'h00, 8'h00, 8'h00, 1'b0, 320, 1'b0, 0, 0, 16, 0);

        // Space held through the retire frame.
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 432, 16, 0);
        for (int j = 1; j <= 107; j++) frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 10'(432 - 4 * j), 16, 0);
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b0, 0, 0, 16, 0);
`ifdef PLAYER_AUTOFIRE_EN
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 432, 16, 0);
`else
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b0, 0, 0, 16, 0);
        frame(8'h00, 8'h00, 8'h00, 1'b0, 320, 1'b0, 0, 0, 16, 0);
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 432, 16, 0);
`endif

        do_reset();

        // Hit during the SHOT cycle beats both movement and relaunch.
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 432, 17, 1);
        frame(8'h00, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 428, 17, 1);
        frame(8'h2C, 8'h00, 8'h00, 1'b1, 320, 1'b0, 0, 0, 17, 1);
        frame(8'h2C, 8'h00, 8'h00, 1'b0, 320, 1'b1, 320, 432, 17, 1);
        frame(8'h00, 8'h00, 8'h00, 1'b1, 320, 1'b0, 0, 0, 17, 1);

        // Hold right until the right clamp.
        for (int k = 1; k <= 200; k++) begin
            v = 320 + 2 * k;
            if (v > 623) v = 623;
            frame(8'h07, 8'h00, 8'h00, 1'b0, 10'(v), 1'b0, 0, 0, 17, 1);
        end
        frame(8'h04, 8'h00, 8'h00, 1'b0, 621, 1'b0, 0, 0, 17, 1);

        // Reset asserted while the FSM is in MOVE.
        keycode = 8'h04;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check("midrst_PlayerX", PlayerX, 320);
        check("midrst_ShotX", ShotX, 0);
        check("midrst_ShotY", ShotY, 0);
        check("midrst_shot_active", shot_active, 0);
        check("midrst_frame_done", frame_done, 0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        frame(8'h00, 8'h00, 8'h00, 1'b0, 320, 1'b0, 0, 0, 17, 1);

        repeat (10) @(negedge Clk);
        check("scoreboard_pending", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
